// File: rtl/ext_bus_bridge_pkg.sv
// rtl/ext_bus_bridge_pkg.sv - shared encodings for the EXT bus bridge
package ext_bus_bridge_pkg;

    localparam logic [3:0] HSIZE_BYTE = 4'd0;
    localparam logic [3:0] HSIZE_HALF = 4'd1;
    localparam logic [3:0] HSIZE_WORD = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERR    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/ext_bus_bridge_be_decode.sv
// rtl/ext_bus_bridge_be_decode.sv - transfer size/alignment to byte-enable decode
module ext_bus_bridge_be_decode
    import ext_bus_bridge_pkg::*;
(
    input  logic [3:0] size,
    input  logic [1:0] addr_lo,
    output logic       legal,
    output logic [3:0] be
);

    // Only naturally aligned byte, half and word transfers are legal.
    always_comb begin
        legal = 1'b0;
        be    = 4'b0000;
        case (size)
            HSIZE_BYTE: begin
                legal = 1'b1;
                be    = 4'b0001 << addr_lo;
            end
            HSIZE_HALF: begin
                if (addr_lo == 2'd0) begin
                    legal = 1'b1;
                    be    = 4'b0011;
                end else if (addr_lo == 2'd2) begin
                    legal = 1'b1;
                    be    = 4'b1100;
                end
            end
            HSIZE_WORD: begin
                if (addr_lo == 2'd0) begin
                    legal = 1'b1;
                    be    = 4'b1111;
                end
            end
            default: begin
                legal = 1'b0;
                be    = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/ext_bus_bridge.sv
// rtl/ext_bus_bridge.sv - EXT bus slave to word-addressed peripheral port bridge
module ext_bus_bridge
    import ext_bus_bridge_pkg::*;
#(
    parameter int          AWIDTH   = 16,
    parameter int          DEV_AW   = 4,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EXT_HSEL,
    input  logic              EXT_HWRITE,
    input  logic [AWIDTH-1:0] EXT_HADDR,
    input  logic [3:0]        EXT_HSIZE,
    input  logic [31:0]       EXT_HWDATA,
    output logic [31:0]       EXT_HRDATA,
    output logic              EXT_HREADYOUT,
    output logic              dev_req,
    output logic              dev_we,
    output logic [DEV_AW-1:0] dev_addr,
    output logic [3:0]        dev_be,
    output logic [31:0]       dev_wdata,
    input  logic [31:0]       dev_rdata,
    input  logic              dev_ack,
    input  logic              err_clr,
    output logic              err_sticky
);

    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic            first_q;
    logic [31:0]     wdata_q;
    logic [CW-1:0]   cnt_q;
    logic            be_legal;
    logic [3:0]      be_dec;
    logic            start_access;
    logic            ack_seen;
    logic            timed_out;
    logic            err_set;
    logic            unused_haddr_hi;

    // Upper address bits are decoded into EXT_HSEL upstream.
    assign unused_haddr_hi = ^EXT_HADDR[AWIDTH-1:DEV_AW+2];

    ext_bus_bridge_be_decode u_be_decode (
        .size    (EXT_HSIZE),
        .addr_lo (EXT_HADDR[1:0]),
        .legal   (be_legal),
        .be      (be_dec)
    );

    // State register; reset drops any in-flight access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; address phase accepted only while ready.
    always_comb begin
        state_nxt     = state;
        EXT_HREADYOUT = 1'b1;
        dev_req       = 1'b0;
        start_access  = 1'b0;
        ack_seen      = 1'b0;
        timed_out     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (EXT_HSEL) begin
                    if (be_legal) begin
                        state_nxt    = ST_ACCESS;
                        start_access = 1'b1;
                    end else begin
                        state_nxt = ST_ERR;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                EXT_HREADYOUT = 1'b0;
                dev_req       = 1'b1;
                if (dev_ack) begin
                    ack_seen  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (cnt_q == T_LAST) begin
                    timed_out = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_ERR: begin
                EXT_HREADYOUT = 1'b0;
                state_nxt     = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign err_set   = timed_out | (state == ST_ERR);
    assign dev_wdata = first_q ? EXT_HWDATA : wdata_q;

    // Command latch: held stable for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dev_we   <= 1'b0;
            dev_addr <= '0;
            dev_be   <= 4'b0000;
        end else if (start_access) begin
            dev_we   <= EXT_HWRITE;
            dev_addr <= EXT_HADDR[DEV_AW+1:2];
            dev_be   <= be_dec;
        end
    end

    // Write data passes straight through in the first access cycle, then is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= 1'b0;
            wdata_q <= 32'h0;
        end else begin
            first_q <= start_access;
            if (first_q) begin
                wdata_q <= EXT_HWDATA;
            end
        end
    end

    // Cycles spent waiting for dev_ack in the current access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start_access) begin
            cnt_q <= '0;
        end else if ((state == ST_ACCESS) && !ack_seen && !timed_out) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Read data register; writes return zero, errors return the marker word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EXT_HRDATA <= 32'h0;
        end else if (ack_seen) begin
            EXT_HRDATA <= dev_we ? 32'h0 : dev_rdata;
        end else if (err_set) begin
            EXT_HRDATA <= ERR_DATA;
        end
    end

    // Sticky error flag; a new error beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (err_set) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ext_bus_bridge.sv
// tb/tb_ext_bus_bridge.sv - self-checking bench for ext_bus_bridge
module tb_ext_bus_bridge;

    localparam int          TMO     = 4;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        EXT_HSEL;
    logic        EXT_HWRITE;
    logic [15:0] EXT_HADDR;
    logic [3:0]  EXT_HSIZE;
    logic [31:0] EXT_HWDATA;
    logic [31:0] EXT_HRDATA;
    logic        EXT_HREADYOUT;
    logic        dev_req;
    logic        dev_we;
    logic [3:0]  dev_addr;
    logic [3:0]  dev_be;
    logic [31:0] dev_wdata;
    logic [31:0] dev_rdata;
    logic        dev_ack;
    logic        err_clr;
    logic        err_sticky;

    int   total;
    int   bad;
    logic err_model;

    ext_bus_bridge #(
        .AWIDTH   (16),
        .DEV_AW   (4),
        .TIMEOUT  (TMO),
        .ERR_DATA (ERR_VAL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .EXT_HSEL      (EXT_HSEL),
        .EXT_HWRITE    (EXT_HWRITE),
        .EXT_HADDR     (EXT_HADDR),
        .EXT_HSIZE     (EXT_HSIZE),
        .EXT_HWDATA    (EXT_HWDATA),
        .EXT_HRDATA    (EXT_HRDATA),
        .EXT_HREADYOUT (EXT_HREADYOUT),
        .dev_req       (dev_req),
        .dev_we        (dev_we),
        .dev_addr      (dev_addr),
        .dev_be        (dev_be),
        .dev_wdata     (dev_wdata),
        .dev_rdata     (dev_rdata),
        .dev_ack       (dev_ack),
        .err_clr       (err_clr),
        .err_sticky    (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete transfer, starting in a cycle where the bridge is ready and
    // returning at the DONE cycle, so a following call is back-to-back.
    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [3:0] size,
                        input logic [31:0] wd, input int lat, input logic [31:0] rd,
                        input string tag);
        int          nb;
        int          low;
        int          low_exp;
        logic        legal;
        logic        fin;
        logic [3:0]  be_exp;
        logic [3:0]  addr_exp;
        logic [31:0] hr_exp;
        nb       = (size <= 4'd2) ? (1 << size) : 0;
        legal    = (nb != 0) && ((int'(addr) % nb) == 0);
        be_exp   = legal ? 4'(((1 << nb) - 1) << (int'(addr) % 4)) : 4'h0;
        addr_exp = 4'((int'(addr) / 4) % 16);
        if (!legal) begin
            low_exp   = 1;
            hr_exp    = ERR_VAL;
            err_model = 1'b1;
        end else if (lat <= TMO) begin
            low_exp = lat;
            hr_exp  = wr ? 32'h0 : rd;
        end else begin
            low_exp   = TMO;
            hr_exp    = ERR_VAL;
            err_model = 1'b1;
        end

        total++;
        if (EXT_HREADYOUT !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_at_addr: got %b want 1", tag, EXT_HREADYOUT);
        end
        EXT_HSEL   = 1'b1;
        EXT_HWRITE = wr;
        EXT_HADDR  = addr;
        EXT_HSIZE  = size;
        @(negedge clk);
        EXT_HSEL   = 1'b0;
        EXT_HWDATA = wr ? wd : $urandom;
        low = 0;
        fin = 1'b0;
        for (int k = 1; k <= TMO + 3; k++) begin
            dev_ack   = legal && (k == lat);
            dev_rdata = dev_ack ? rd : $urandom;
            #1;
            if (EXT_HREADYOUT === 1'b1) begin
                fin = 1'b1;
                break;
            end
            low++;
            total++;
            if (dev_req !== legal) begin
                bad++;
                $display("FAIL %s dev_req cyc%0d: got %b want %b", tag, k, dev_req, legal);
            end
            if (legal) begin
                total++;
                if (dev_we !== wr || dev_addr !== addr_exp || dev_be !== be_exp) begin
                    bad++;
                    $display("FAIL %s cmd cyc%0d: got we=%b addr=%h be=%b want we=%b addr=%h be=%b",
                             tag, k, dev_we, dev_addr, dev_be, wr, addr_exp, be_exp);
                end
                if (wr) begin
                    total++;
                    if (dev_wdata !== wd) begin
                        bad++;
                        $display("FAIL %s dev_wdata cyc%0d: got %h want %h", tag, k, dev_wdata, wd);
                    end
                end
            end
            @(negedge clk);
        end
        dev_ack = 1'b0;
        total++;
        if (!fin || low != low_exp) begin
            bad++;
            $display("FAIL %s ready_low_cycles: got %0d (done=%b) want %0d", tag, low, fin, low_exp);
        end
        total++;
        if (EXT_HRDATA !== hr_exp) begin
            bad++;
            $display("FAIL %s hrdata: got %h want %h", tag, EXT_HRDATA, hr_exp);
        end
        total++;
        if (dev_req !== 1'b0) begin
            bad++;
            $display("FAIL %s dev_req_in_done: got %b want 0", tag, dev_req);
        end
        total++;
        if (err_sticky !== err_model) begin
            bad++;
            $display("FAIL %s err_sticky: got %b want %b", tag, err_sticky, err_model);
        end
    endtask

    task automatic pulse_err_clr(input string tag);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr   = 1'b0;
        err_model = 1'b0;
        #1;
        total++;
        if (err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL %s err_clr: got %b want 0", tag, err_sticky);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (EXT_HREADYOUT !== 1'b1 || EXT_HRDATA !== 32'h0 || dev_req !== 1'b0 || dev_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_a: got rdy=%b hr=%h req=%b we=%b want 1 0 0 0",
                     EXT_HREADYOUT, EXT_HRDATA, dev_req, dev_we);
        end
        total++;
        if (dev_addr !== 4'h0 || dev_be !== 4'h0 || dev_wdata !== 32'h0 || err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL reset_b: got addr=%h be=%b wd=%h err=%b want 0 0 0 0",
                     dev_addr, dev_be, dev_wdata, err_sticky);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (EXT_HREADYOUT !== 1'b1 || dev_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got rdy=%b req=%b want 1 0", EXT_HREADYOUT, dev_req);
        end
    endtask

    task automatic test_directed();
        xfer(1'b1, 16'h0008, 4'd2, 32'h1234_5678, 1, 32'h0, "word_write");
        @(negedge clk);
        xfer(1'b0, 16'h0004, 4'd2, 32'h0, 3, 32'hCAFE_F00D, "word_read_lat3");
        @(negedge clk);
        xfer(1'b1, 16'h0003, 4'd0, 32'hAABB_CCDD, 2, 32'h0, "byte_at_3");
        @(negedge clk);
        xfer(1'b0, 16'h0002, 4'd1, 32'h0, 1, 32'h0BAD_F00D, "half_at_2");
        @(negedge clk);
        xfer(1'b0, 16'h0001, 4'd1, 32'h0, 1, 32'h0, "half_at_1_illegal");
        @(negedge clk);
        pulse_err_clr("clr_after_illegal");
    endtask

    task automatic test_timeout();
        @(negedge clk);
        xfer(1'b0, 16'h0020, 4'd2, 32'h0, TMO + 10, 32'h1111_2222, "timeout_read");
        @(negedge clk);
        pulse_err_clr("clr_after_timeout");
        @(negedge clk);
        xfer(1'b0, 16'h0024, 4'd2, 32'h0, TMO, 32'h3333_4444, "ack_at_limit");
    endtask

    task automatic test_clr_priority();
        @(negedge clk);
        err_clr = 1'b1;
        xfer(1'b1, 16'h0006, 4'd2, 32'h5555_6666, 1, 32'h0, "illegal_with_clr");
        err_clr = 1'b0;
        @(negedge clk);
        pulse_err_clr("clr_after_priority");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        xfer(1'b1, 16'h003C, 4'd2, 32'h0F0F_A5A5, 2, 32'h0, "b2b_write");
        xfer(1'b0, 16'h0030, 4'd2, 32'h0, 1, 32'h8765_4321, "b2b_read");
        xfer(1'b0, 16'h0031, 4'd0, 32'h0, 1, 32'h0000_00FE, "b2b_byte_read");
    endtask

    task automatic test_random();
        logic        wr;
        logic [15:0] addr;
        logic [3:0]  size;
        int          lat;
        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = 16'($urandom_range(0, 65535));
            size = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
            if (size == 4'd1) addr[0] = ($urandom_range(0, 3) == 0);
            if (size == 4'd2) addr[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            lat  = $urandom_range(1, TMO + 2);
            xfer(wr, addr, size, $urandom, lat, $urandom, "random");
            if (err_model && $urandom_range(0, 1) == 1) begin
                pulse_err_clr("random_clr");
            end else if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        EXT_HSEL   = 1'b1;
        EXT_HWRITE = 1'b0;
        EXT_HADDR  = 16'h0010;
        EXT_HSIZE  = 4'd2;
        @(negedge clk);
        EXT_HSEL = 1'b0;
        dev_ack  = 1'b0;
        #1;
        total++;
        if (dev_req !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_pre: dev_req got %b want 1", dev_req);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        err_model = 1'b0;
        total++;
        if (dev_req !== 1'b0 || EXT_HREADYOUT !== 1'b1 || EXT_HRDATA !== 32'h0 || err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got req=%b rdy=%b hr=%h err=%b want 0 1 0 0",
                     dev_req, EXT_HREADYOUT, EXT_HRDATA, err_sticky);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(1'b0, 16'h0018, 4'd2, 32'h0, 2, 32'h2468_ACE0, "after_mid_reset");
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        err_model  = 1'b0;
        rst        = 1'b1;
        EXT_HSEL   = 1'b0;
        EXT_HWRITE = 1'b0;
        EXT_HADDR  = 16'h0;
        EXT_HSIZE  = 4'd0;
        EXT_HWDATA = 32'h0;
        dev_rdata  = 32'h0;
        dev_ack    = 1'b0;
        err_clr    = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_timeout();
        test_clr_priority();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
